// File: rtl/adder_result_sink.sv
// Result sink for adder64: captures rdy-flagged sums into a FWFT FIFO and keeps
// a running XOR checksum plus a saturating count of words dropped on overflow.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif

module adder_result_sink #(
    parameter int unsigned DATA_W = `LEN_DATA,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sum,
    input  logic              rdy,
    input  logic              clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic [DATA_W-1:0] chk,
    output logic [7:0]        ovf_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wp_q, wp_d;
    logic [PtrW-1:0]   rp_q, rp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic [7:0]        ovf_q, ovf_d;
    logic              push, pop, drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign out_data  = mem_q[rp_q];
    assign chk       = chk_q;
    assign ovf_cnt   = ovf_q;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = en && rdy && (!full || pop);
    assign drop = en && rdy && full && !pop;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        chk_d   = clr ? '0 : chk_q;
        ovf_d   = clr ? '0 : ovf_q;

        if (push) begin
            wp_d  = wp_q + PtrW'(1);
            chk_d = chk_d ^ sum;
        end
        if (pop) begin
            rp_d = rp_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop && (ovf_d != 8'hff)) begin
            ovf_d = ovf_d + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            chk_q   <= '0;
            ovf_q   <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            chk_q   <= chk_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= sum;
        end
    end

endmodule

// File: tb/tb_adder_result_sink.sv
// Directed bench for adder_result_sink: reset, fill/drain, overflow saturation,
// full push+pop, clear, random streaming against a queue model, async reset.
module tb_adder_result_sink;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] sum;
    logic          rdy;
    logic          clr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          full;
    logic [DW-1:0] chk;
    logic [7:0]    ovf_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_result_sink #(
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sum      (sum),
        .rdy      (rdy),
        .clr      (clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .full     (full),
        .chk      (chk),
        .ovf_cnt  (ovf_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before calling take effect at the next edge; outputs settle by #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] mchk;
    int          mov;
    int          sz;
    bit          mpop;

    initial begin
        rst = 1'b1; en = 1'b0; sum = '0; rdy = 1'b0; clr = 1'b0; out_ready = 1'b0;

        // Reset state while held, then release with en=0 and rdy toggling
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_chk", chk, 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdy = (i % 2 == 0);
            sum = 64'hdead_0000 + 64'(i);
            step();
            check("idle_count", 64'(count), 64'd0);
            check("idle_valid", 64'(out_valid), 64'd0);
            check("idle_chk", chk, 64'd0);
            check("idle_ovf", 64'(ovf_cnt), 64'd0);
        end

        // Fill 1..4 then drain
        en = 1'b1; rdy = 1'b1; out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sum = 64'(i);
            step();
        end
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd4);
        check("fill_chk", chk, 64'h4);
        en = 1'b0; rdy = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data", out_data, 64'(i));
            step();
        end
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_chk", chk, 64'h4);

        // Overflow: fill 0x10..0x13, then 3 drops, then saturate
        out_ready = 1'b0; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum = 64'h10 + 64'(i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            sum = 64'hbad0 + 64'(i);
            step();
        end
        check("ovf_3", 64'(ovf_cnt), 64'd3);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_head", out_data, 64'h10);
        check("ovf_chk", chk, 64'h4);
        for (int i = 0; i < 300; i++) begin
            sum = 64'(i);
            step();
        end
        check("ovf_sat", 64'(ovf_cnt), 64'd255);
        en = 1'b0; rdy = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", out_data, 64'h10 + 64'(i));
            step();
        end
        check("ovf_empty", 64'(out_valid), 64'd0);

        // Clear concurrent with a push of 0x55
        out_ready = 1'b0; en = 1'b1; rdy = 1'b1; clr = 1'b1; sum = 64'h55;
        step();
        clr = 1'b0;
        check("clr_push_chk", chk, 64'h55);
        check("clr_push_ovf", 64'(ovf_cnt), 64'd0);
        check("clr_push_count", 64'(count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            sum = 64'h56 + 64'(i);
            step();
        end
        check("clr_full", 64'(full), 64'd1);
        // Clear with a simultaneous drop leaves the counter at 1
        sum = 64'h99; clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_drop_ovf", 64'(ovf_cnt), 64'd1);
        check("clr_drop_chk", chk, 64'h0);
        en = 1'b0; rdy = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("clr_drain", out_data, 64'h55 + 64'(i));
            step();
        end

        // Full FIFO with push+pop in the same cycle
        out_ready = 1'b0; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sum = 64'ha + 64'(i);
            step();
        end
        check("pp_full", 64'(full), 64'd1);
        check("pp_chk0", chk, 64'h0);
        sum = 64'he; out_ready = 1'b1;
        check("pp_head", out_data, 64'ha);
        step();
        check("pp_count", 64'(count), 64'd4);
        check("pp_ovf", 64'(ovf_cnt), 64'd1);
        check("pp_chk", chk, 64'he);
        en = 1'b0; rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", out_data, 64'hb + 64'(i));
            step();
        end
        check("pp_empty", 64'(out_valid), 64'd0);

        // Random streaming against a queue model
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("stream_clr_chk", chk, 64'h0);
        check("stream_clr_ovf", 64'(ovf_cnt), 64'd0);
        mchk = '0;
        mov  = 0;
        en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            sum = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            sz = q.size();
            check("stream_count", 64'(count), 64'(sz));
            if (sz > 0) begin
                check("stream_data", out_data, q[0]);
            end
            mpop = (sz > 0) && out_ready;
            if (mpop) begin
                void'(q.pop_front());
            end
            if ((sz < int'(DEPTH)) || mpop) begin
                q.push_back(sum);
                mchk = mchk ^ sum;
            end else if (mov < 255) begin
                mov++;
            end
            step();
        end
        en = 1'b0; rdy = 1'b0;
        check("stream_chk", chk, mchk);
        check("stream_ovf", 64'(ovf_cnt), 64'(mov));
        out_ready = 1'b1;
        while (q.size() > 0) begin
            check("stream_drain", out_data, q.pop_front());
            step();
        end
        check("stream_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset with 3 entries held
        out_ready = 1'b0; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sum = 64'h70 + 64'(i);
            step();
        end
        en = 1'b0; rdy = 1'b0;
        check("arst_pre_count", 64'(count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_full", 64'(full), 64'd0);
        check("arst_chk", chk, 64'h0);
        check("arst_ovf", 64'(ovf_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_post_count", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
